output_interface: RTL and testbench
===================================

Name: output_interface

Overview:
- Output-port stage of the mesh router; the transmit-side counterpart of the per-direction input interface.
- Collects route requests aimed at one output direction from up to four input interfaces and arbitrates them round-robin.
- Captures the granted flit into a small output FIFO, pulses the matching buf_clear back to the granted input so it frees its channel buffer, and drives the downstream link with the so/ro send-receive handshake.

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- DIRECTION, 5'b10000, one-hot direction this output serves (L:10000, R:01000, U:00100, D:00010, PE:00001); informational only, does not alter logic.
- FIFO_DEPTH, 2, output FIFO entries; power of two, 1 to 8 (1 = single register).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_1..req_4  input  5 each  route request from candidate input k; nonzero means valid, value is don't-care.
- data_1..data_4  input  DATA_WIDTH each  flit from candidate input k; stable while req_k nonzero.
- buf_clear_1..buf_clear_4  output  1 each  grant/clear pulse to input k.
- so  output  1  send: datao holds a valid flit.
- ro  input  1  downstream receive-ready.
- datao  output  DATA_WIDTH  flit to downstream.
- fifo_full  output  1  status, count == FIFO_DEPTH.

Behaviour:
- Reset (rst low, asynchronous): FIFO count, read and write pointers = 0; so = 0; datao = 0; round-robin pointer = input 1; buf_clear_1..4 forced 0 while rst low.
- valid_k = |req_k.
- Arbitration is combinational each cycle.
  - If FIFO not full and any valid_k: grant the first valid input in order ptr, ptr+1, ... wrapping 4 -> 1.
  - Exactly one buf_clear_k is high, only in the grant cycle; all are 0 when nothing is granted or the FIFO is full.
  - Full is evaluated on the registered count. No grant while full, even if a pop occurs in the same cycle.
- Capture at the clock edge ending the grant cycle:
  - data_k is written to the FIFO at the write pointer, and the write pointer wraps modulo FIFO_DEPTH.
  - The round-robin pointer moves to the granted index + 1 (4 -> 1) and is unchanged with no grant.
  - The input clears its buffer on the same edge, so req_k drops the next cycle. A single request therefore produces a 1-cycle buf_clear pulse.
- Output side: so = (count != 0); datao = FIFO head, registered from FIFO storage, never combinational from data_k.
  - Minimum latency is a grant in cycle N, then so high with the flit in cycle N+1.
  - Transfer happens when so && ro at a rising edge: read pointer advances and the next head appears the following cycle.
  - While ro is low, so and datao hold stable.
- Simultaneous push and pop with the FIFO not full: count unchanged, and both pointers advance.
- When empty, datao holds the last popped value (0 after reset); it is not cleared.
- Count is width clog2(FIFO_DEPTH)+1, never exceeds FIFO_DEPTH, and never underflows (pop gated by so).
- Reset asserted mid-transfer: the FIFO content is discarded, so drops immediately (asynchronous), and a flit granted in that cycle is lost by design.
- No flit modification and no hop-count arithmetic in this block.

Optional Feature:
- Macro OUTPUT_FIXED_PRIORITY_EN.
- When defined: the round-robin pointer is removed and grant is fixed priority 1 > 2 > 3 > 4.
- When undefined (default): round-robin as above.
- All other behaviour is identical.

Test Plan:
- Reset then idle: rst low for 2 cycles with all req = 0 -> so=0, datao=0, all buf_clear=0, fifo_full=0.
- Single flit: req_2=5'b01000, data_2=64'hA5 at cycle N, ro=1 -> buf_clear_2 high in cycle N only; so=1 with datao=64'hA5 in N+1; so=0 in N+2.
- Round-robin fairness: req_1..req_4 all held valid (inputs re-request after clear), ro=1 -> buf_clear sequence 1,2,3,4,1 on consecutive cycles; with the macro defined -> 1,1,1,...
- Backpressure and full: FIFO_DEPTH=2, ro=0, req_1 and req_3 valid with data 64'h11 and 64'h33 -> two grants then fifo_full=1, no further buf_clear. Then ro=1 -> datao 64'h11 then 64'h33 in order, and a grant resumes the cycle after count drops.
- Simultaneous push and pop: count=1, ro=1 and req_4 valid in the same cycle -> count stays 1, head advances to the new flit, no flit lost or duplicated.
- Reset mid-stream: rst pulled low while so=1 and a grant is active -> so and buf_clear drop immediately; after release FIFO is empty and the round-robin pointer is back at 1.

Source files
------------

// File: rtl/output_interface_if.sv
// Signal bundle between the router core (request side) and one output port,
// plus the so/ro link to the downstream neighbour.
interface output_interface_if #(
    parameter int DATA_WIDTH = 64
);
    logic [4:0]            req_1, req_2, req_3, req_4;
    logic [DATA_WIDTH-1:0] data_1, data_2, data_3, data_4;
    logic                  buf_clear_1, buf_clear_2, buf_clear_3, buf_clear_4;
    logic                  so;
    logic                  ro;
    logic [DATA_WIDTH-1:0] datao;
    logic                  fifo_full;

    // master: the requesting inputs plus the downstream receiver
    modport master (
        output req_1, req_2, req_3, req_4,
        output data_1, data_2, data_3, data_4,
        output ro,
        input  buf_clear_1, buf_clear_2, buf_clear_3, buf_clear_4,
        input  so, datao, fifo_full
    );

    // slave: the output port stage itself
    modport slave (
        input  req_1, req_2, req_3, req_4,
        input  data_1, data_2, data_3, data_4,
        input  ro,
        output buf_clear_1, buf_clear_2, buf_clear_3, buf_clear_4,
        output so, datao, fifo_full
    );
endinterface

// File: rtl/output_interface.sv
// Mesh-router output port: round-robin arbiter over four inputs, small output FIFO,
// so/ro downstream link. Define OUTPUT_FIXED_PRIORITY_EN for fixed priority 1>2>3>4.
module output_interface #(
    parameter int         DATA_WIDTH = 64,
    parameter logic [4:0] DIRECTION  = 5'b10000,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output_interface_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic                  unused_dir;
    logic [3:0]            valid;
    logic [DATA_WIDTH-1:0] data_in [4];
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] datao_q, datao_d;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  full, push, pop, so;
    logic [1:0]            rr_base, grant_idx, scan_idx;
    logic [3:0]            clear_vec;

    assign unused_dir = ^DIRECTION;

    assign valid      = {|bus.req_4, |bus.req_3, |bus.req_2, |bus.req_1};
    assign data_in[0] = bus.data_1;
    assign data_in[1] = bus.data_2;
    assign data_in[2] = bus.data_3;
    assign data_in[3] = bus.data_4;

`ifdef OUTPUT_FIXED_PRIORITY_EN
    assign rr_base = 2'd0;
`else
    logic [1:0] rr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= 2'd0;
        end else if (push) begin
            rr_q <= grant_idx + 2'd1;
        end
    end

    assign rr_base = rr_q;
`endif

    // Full uses the registered count, so a pop this cycle cannot free a slot for a grant.
    assign full = (count_q == DEPTH_C);

    always_comb begin
        push      = 1'b0;
        grant_idx = 2'd0;
        scan_idx  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            scan_idx = rr_base + 2'(i);
            if (!push && valid[scan_idx]) begin
                push      = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (full) begin
            push = 1'b0;
        end
    end

    assign clear_vec       = (push && rst) ? (4'b0001 << grant_idx) : 4'b0000;
    assign bus.buf_clear_1 = clear_vec[0];
    assign bus.buf_clear_2 = clear_vec[1];
    assign bus.buf_clear_3 = clear_vec[2];
    assign bus.buf_clear_4 = clear_vec[3];

    // Downstream link: a flit moves on every rising edge where so && ro; so/datao hold otherwise.
    assign so            = (count_q != '0);
    assign pop           = so && bus.ro;
    assign wdata         = data_in[grant_idx];
    assign bus.so        = so;
    assign bus.datao     = datao_q;
    assign bus.fifo_full = full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        datao_d  = datao_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The new head is the incoming flit when nothing older survives this edge.
        if (count_d != '0) begin
            if ((count_q == '0) || (pop && (count_q == CNT_W'(1)))) begin
                datao_d = wdata;
            end else begin
                datao_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            datao_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            datao_q  <= datao_d;
        end
    end
endmodule

// File: tb/tb_output_interface.sv
// Bench for output_interface: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_output_interface;
    localparam int DW    = 64;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_interface_if #(.DATA_WIDTH(DW)) bus ();

    output_interface #(
        .DATA_WIDTH(DW),
        .DIRECTION (5'b10000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [4:0]    req_a [4];
    logic [DW-1:0] dat_a [4];
    logic          ro_r;
    logic [3:0]    bc;

    assign bus.req_1  = req_a[0];
    assign bus.req_2  = req_a[1];
    assign bus.req_3  = req_a[2];
    assign bus.req_4  = req_a[3];
    assign bus.data_1 = dat_a[0];
    assign bus.data_2 = dat_a[1];
    assign bus.data_3 = dat_a[2];
    assign bus.data_4 = dat_a[3];
    assign bus.ro     = ro_r;
    assign bc = {bus.buf_clear_4, bus.buf_clear_3, bus.buf_clear_2, bus.buf_clear_1};

    // Input-side sources: each holds a number of pending flits and drops one per clear.
    int            src_cnt  [4];
    int            src_seq  [4];
    logic [DW-1:0] src_base [4];
    logic [3:0]    clr_seen = 4'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, round-robin pointer as an input number.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_last = '0;
    int            m_ptr  = 0;
    int            m_g;
    int            c_g;

    function automatic int model_grant();
        if (exp_q.size() >= DEPTH) return -1;
        for (int i = 0; i < 4; i++) begin
`ifdef OUTPUT_FIXED_PRIORITY_EN
            int k = i;
`else
            int k = (m_ptr + i) % 4;
`endif
            if (req_a[k] != 5'd0) return k;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_last = '0;
            m_ptr  = 0;
        end else begin
            m_g = model_grant();
            if (exp_q.size() != 0 && ro_r) m_last = exp_q.pop_front();
            if (m_g >= 0) begin
                exp_q.push_back(dat_a[m_g]);
                m_ptr = (m_g + 1) % 4;
            end
        end
    end

    logic [3:0]    e_bc;
    logic          e_so, e_full;
    logic [DW-1:0] e_d;

    always @(negedge clk) begin
        clr_seen = bc;
        if (!rst) begin
            e_bc = 4'b0; e_so = 1'b0; e_d = '0; e_full = 1'b0;
        end else begin
            c_g    = model_grant();
            e_bc   = (c_g >= 0) ? 4'(1 << c_g) : 4'b0;
            e_so   = (exp_q.size() != 0);
            e_d    = e_so ? exp_q[0] : m_last;
            e_full = (exp_q.size() == DEPTH);
        end
        check("cyc_buf_clear", DW'(bc), DW'(e_bc));
        check("cyc_so", DW'(bus.so), DW'(e_so));
        check("cyc_datao", bus.datao, e_d);
        check("cyc_fifo_full", DW'(bus.fifo_full), DW'(e_full));
    end

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req_a[k] = (src_cnt[k] > 0) ? 5'(1 << (4 - k)) : 5'd0;
            dat_a[k] = src_base[k] + DW'(src_seq[k]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (clr_seen[k] && src_cnt[k] > 0) begin
                src_cnt[k]--;
                src_seq[k]++;
            end
        end
        drive();
    endtask

    task automatic load(input int port, input logic [DW-1:0] base, input int n);
        src_cnt[port-1]  = n;
        src_seq[port-1]  = 0;
        src_base[port-1] = base;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ro_r = 1'b0;
        for (int k = 0; k < 4; k++) src_cnt[k] = 0;
        drive();
        repeat (2) step();
        #1;
        check("rst_so", DW'(bus.so), '0);
        check("rst_datao", bus.datao, '0);
        check("rst_buf_clear", DW'(bc), '0);
        check("rst_fifo_full", DW'(bus.fifo_full), '0);
        rst = 1'b1;
    endtask

    int e_rr [5];

    initial begin
        rst  = 1'b1;
        ro_r = 1'b0;
        for (int k = 0; k < 4; k++) begin
            src_cnt[k] = 0; src_seq[k] = 0; src_base[k] = '0;
        end
        drive();
        #1;
        do_reset();

        // Single flit through input 2
        ro_r = 1'b1;
        load(2, 64'hA5, 1);
        #1;
        check("single_clear_N", DW'(bc), DW'(4'b0010));
        check("single_so_N", DW'(bus.so), '0);
        step(); #1;
        check("single_clear_N1", DW'(bc), '0);
        check("single_so_N1", DW'(bus.so), 64'd1);
        check("single_datao_N1", bus.datao, 64'hA5);
        step(); #1;
        check("single_so_N2", DW'(bus.so), '0);
        check("single_hold_N2", bus.datao, 64'hA5);

        // Arbitration order with all four inputs requesting
        do_reset();
`ifdef OUTPUT_FIXED_PRIORITY_EN
        e_rr = '{1, 1, 1, 1, 1};
`else
        e_rr = '{1, 2, 4, 8, 1};
`endif
        ro_r = 1'b1;
        load(1, 64'h100, 6);
        load(2, 64'h200, 6);
        load(3, 64'h300, 6);
        load(4, 64'h400, 6);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_order", DW'(bc), DW'(e_rr[i]));
            step();
        end

        // Backpressure, full, drain in order, grant resumes, push+pop
        do_reset();
        load(1, 64'h11, 1);
        load(3, 64'h33, 1);
        #1;
        check("bp_clear1", DW'(bc), DW'(4'b0001));
        step(); #1;
        check("bp_clear3", DW'(bc), DW'(4'b0100));
        check("bp_head11", bus.datao, 64'h11);
        step(); #1;
        check("bp_full", DW'(bus.fifo_full), 64'd1);
        load(2, 64'h22, 1);
        #1;
        check("bp_no_grant_full", DW'(bc), '0);
        step(); #1;
        check("bp_still_full", DW'(bus.fifo_full), 64'd1);
        check("bp_hold11", bus.datao, 64'h11);
        ro_r = 1'b1;
        #1;
        check("bp_no_grant_pop", DW'(bc), '0);
        step(); #1;
        check("bp_head33", bus.datao, 64'h33);
        check("bp_not_full", DW'(bus.fifo_full), '0);
        check("bp_grant_resume", DW'(bc), DW'(4'b0010));
        step(); #1;
        check("bp_head22", bus.datao, 64'h22);
        check("bp_so_22", DW'(bus.so), 64'd1);
        step(); #1;
        check("bp_empty", DW'(bus.so), '0);

        // Simultaneous push and pop at count 1
        do_reset();
        load(1, 64'h77, 1);
        step(); #1;
        check("pp_head77", bus.datao, 64'h77);
        ro_r = 1'b1;
        load(4, 64'h44, 1);
        #1;
        check("pp_clear4", DW'(bc), DW'(4'b1000));
        step(); #1;
        check("pp_head44", bus.datao, 64'h44);
        check("pp_count1_so", DW'(bus.so), 64'd1);
        check("pp_count1_full", DW'(bus.fifo_full), '0);
        step(); #1;
        check("pp_drained", DW'(bus.so), '0);
        check("pp_hold44", bus.datao, 64'h44);

        // Reset while a flit is buffered and a grant is active
        do_reset();
        load(1, 64'hAA, 1);
        step();
        load(2, 64'hBB, 1);
        #1;
        check("mr_grant_before", DW'(bc), DW'(4'b0010));
        check("mr_so_before", DW'(bus.so), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mr_so_drop", DW'(bus.so), '0);
        check("mr_clear_drop", DW'(bc), '0);
        check("mr_datao_clr", bus.datao, '0);
        step();
        load(1, 64'hCC, 1);
        rst = 1'b1;
        #1;
        check("mr_ptr_at_1", DW'(bc), DW'(4'b0001));
        check("mr_empty", DW'(bus.so), '0);
        step(); #1;
        check("mr_headCC", bus.datao, 64'hCC);
        check("mr_then_2", DW'(bc), DW'(4'b0010));
        step(); #1;
        check("mr_full", DW'(bus.fifo_full), 64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
